elevator_car_ctrl: RTL
======================

Name: elevator_car_ctrl

Overview:
- Car motion controller directly downstream of the request queue.
- Consumes the queue's head destination (one-hot floor, 4'b1111 = empty) and its go flag.
- Paces travel between floors and door dwell from a slow tick enable.
- Produces the one-hot current-floor vector that the queue samples as its current state.

Parameters:
- TRAVEL_TICKS, 4: tick pulses spent travelling between adjacent floors (1..15).
- DOOR_TICKS, 3: tick pulses the door stays open after arrival (1..15).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  single-clk-wide slow-time enable pulse.
- des  in  4  destination floor, one-hot (0001 = floor 1 .. 1000 = floor 4); 1111 = no request.
- go  in  1  high when a pending request is not at the current floor.
- cs  out  4  current floor, one-hot.
- moving  out  1  high while in MOVE.
- dir_up  out  1  travel direction; 1 = up. Holds its last value when not moving.
- door_open  out  1  high while in DOOR.
- arrived  out  1  one-clk pulse on the cycle the car reaches its latched target.

Behaviour:
- Reset values (asynchronous, take effect immediately): cs = 0001, state = IDLE, tgt = 0001, travel_cnt = 0, door_cnt = 0, moving = 0, dir_up = 0, door_open = 0, arrived = 0.
- Reset mid-operation: the car returns to floor 1, idle, with the door closed. There is no resume.
- des is valid only when it is exactly one-hot. 1111, 0000 or multi-hot values are treated as no request.
- States: IDLE, MOVE, DOOR. The state is encoded in a registered FSM and all outputs are registered.
- IDLE → MOVE requires three conditions: go = 1, des valid, and des != cs.
  - On that transition tgt <= des and travel_cnt <= 0.
  - dir_up <= 1 if the index of des is greater than the index of cs, else 0.
  - The transition does not require tick.
- IDLE with go = 1 and des == cs → DOOR. door_cnt <= 0 and arrived pulses. This is the re-request-at-current-floor case.
- In IDLE, all other cases stay in IDLE.
- MOVE, each clk with tick = 1: travel_cnt increments.
  - When travel_cnt reaches TRAVEL_TICKS-1 on a tick, cs shifts one position toward tgt (left if dir_up, right otherwise) and travel_cnt <= 0.
  - If the shifted cs equals tgt, then on the same edge: state <= DOOR, door_cnt <= 0, arrived = 1 for that cycle.
- MOVE ignores go and des. The target is latched at departure. Intermediate floors are passed without stopping, and cs still steps through them so the queue can retire matching entries.
- cs saturates: it never shifts past 1000 going up or past 0001 going down. If a shift would leave the range, the car enters DOOR at the boundary floor instead. This is a defensive path and is unreachable with valid tgt.
- DOOR, each clk with tick = 1: door_cnt increments. When door_cnt reaches DOOR_TICKS-1 on a tick, state <= IDLE.
- DOOR ignores go and des.
- Outputs:
  - moving = (state == MOVE).
  - door_open = (state == DOOR).
  - arrived is 0 except on the single arrival cycle.
- tick held high continuously is legal and means one count per clk.
- tick = 0 freezes all counters. The FSM stalls in MOVE and DOOR; IDLE departures still occur.
- cs is always exactly one-hot. Verification asserts this every cycle after reset.
- Latency:
  - Departure: 1 clk after go is seen in IDLE.
  - Arrival after departure: |floor delta| × TRAVEL_TICKS ticks.
  - Return to IDLE after arrival: DOOR_TICKS ticks.

Test Plan:
- Reset, then hold go = 0, des = 1111 with tick every cycle for 50 clks → cs = 0001, moving = 0, door_open = 0 throughout.
- From floor 1, des = 1000, go = 1, tick every 4th clk, defaults → dir_up = 1. cs steps 0001 → 0010 → 0100 → 1000, each step after 4 ticks. arrived pulses once at 1000; door_open is high for 3 ticks, then IDLE.
- At floor 4, des = 0010, go = 1 → dir_up = 0. cs goes 1000 → 0100 → 0010 (8 ticks total), then DOOR.
- During a move from 1 to 4, change des to 0100 and drop go after departure → the car still stops only at 1000, and cs passes through 0100.
- IDLE at floor 2 with des = 0010, go = 1 → DOOR entered on the next clk, arrived pulses, cs unchanged. Repeat with des = 0110 or 1111 and go = 1 → the car stays in IDLE.
- Assert rst mid-MOVE (cs = 0100, travel_cnt = 2) → cs = 0001, moving = 0, dir_up = 0 immediately, without waiting for a clk edge. After release, the car stays IDLE until the next valid go.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// Elevator car motion controller: steps the one-hot current floor toward a
// target latched at departure, then holds the door open for a tick-paced dwell.
module elevator_car_ctrl #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] des,
  input  logic       go,
  output logic [3:0] cs,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       arrived
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  localparam logic [3:0] TRAVEL_LAST = 4'(TRAVEL_TICKS - 1);
  localparam logic [3:0] DOOR_LAST   = 4'(DOOR_TICKS - 1);

  logic [1:0] state;
  logic [3:0] tgt;
  logic [3:0] travel_cnt;
  logic [3:0] door_cnt;

  logic       des_valid;
  logic [3:0] cs_step;
  logic       at_limit;

  // 1111, 0000 and multi-hot requests are all ignored.
  assign des_valid = (des != 4'd0) && ((des & (des - 4'd1)) == 4'd0);
  assign cs_step   = dir_up ? {cs[2:0], 1'b0} : {1'b0, cs[3:1]};
  assign at_limit  = dir_up ? cs[3] : cs[0];

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cs         <= 4'b0001;
      tgt        <= 4'b0001;
      travel_cnt <= 4'd0;
      door_cnt   <= 4'd0;
      moving     <= 1'b0;
      dir_up     <= 1'b0;
      door_open  <= 1'b0;
      arrived    <= 1'b0;
    end else begin
      arrived <= 1'b0;
      case (state)
        IDLE: begin
          if (go && des_valid && (des != cs)) begin
            state      <= MOVE;
            moving     <= 1'b1;
            tgt        <= des;
            travel_cnt <= 4'd0;
            // One-hot codes compare in the same order as floor indices.
            dir_up     <= (des > cs);
          end else if (go && (des == cs)) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= 4'd0;
            arrived   <= 1'b1;
          end
        end

        MOVE: begin
          if (tick) begin
            if (travel_cnt == TRAVEL_LAST) begin
              travel_cnt <= 4'd0;
              if (at_limit) begin
                // Defensive: never shift off the end of the shaft.
                state     <= DOOR;
                moving    <= 1'b0;
                door_open <= 1'b1;
                door_cnt  <= 4'd0;
              end else begin
                cs <= cs_step;
                if (cs_step == tgt) begin
                  state     <= DOOR;
                  moving    <= 1'b0;
                  door_open <= 1'b1;
                  door_cnt  <= 4'd0;
                  arrived   <= 1'b1;
                end
              end
            end else begin
              travel_cnt <= travel_cnt + 4'd1;
            end
          end
        end

        DOOR: begin
          if (tick) begin
            if (door_cnt == DOOR_LAST) begin
              state     <= IDLE;
              door_open <= 1'b0;
              door_cnt  <= 4'd0;
            end else begin
              door_cnt <= door_cnt + 4'd1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
